// File: rtl/tb_wait_event_mc.sv
// rtl/tb_wait_event_mc.sv - multi-channel wait-event engine (edge / masked compare, timeout, abort)
module tb_wait_event_mc #(
  parameter int WAIT_SIZE  = 5,
  parameter int WAIT_WIDTH = 8,
  parameter int TO_WIDTH   = 32,
  localparam int SEL_W     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait,
  input  logic                            i_start,
  input  logic [SEL_W-1:0]                i_sel,
  input  logic [2:0]                      i_mode,
  input  logic [WAIT_WIDTH-1:0]           i_mask,
  input  logic [WAIT_WIDTH-1:0]           i_value,
  input  logic [TO_WIDTH-1:0]             i_timeout,
  input  logic                            i_abort,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_timeout,
  output logic                            o_err,
  output logic [TO_WIDTH-1:0]             o_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_t;

  localparam logic [2:0]  M_RISE = 3'd0;
  localparam logic [2:0]  M_FALL = 3'd1;
  localparam logic [2:0]  M_ANY  = 3'd2;
  localparam logic [2:0]  M_EQ   = 3'd3;
  localparam logic [2:0]  M_NEQ  = 3'd4;
  localparam logic [31:0] WAIT_SIZE_U = WAIT_SIZE;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [2:0]             mode_q, mode_d;
  logic [WAIT_WIDTH-1:0]  mask_q, mask_d;
  logic [WAIT_WIDTH-1:0]  value_q, value_d;
  logic [TO_WIDTH-1:0]    timeout_q, timeout_d;
  logic [WAIT_WIDTH-1:0]  prev_q, prev_d;
  logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TO_WIDTH-1:0]    cycles_q, cycles_d;
  logic                   to_flag_q, to_flag_d;
  logic                   err_q, err_d;

  logic [WAIT_WIDTH-1:0]  chan;
  logic [WAIT_WIDTH-1:0]  cur;
  logic [TO_WIDTH-1:0]    cnt_inc;
  logic                   match;
  logic                   start_ok;

  // Pick the selected channel out of the flat bus using the captured index.
  always_comb begin
    chan = '0;
    for (int k = 0; k < WAIT_SIZE; k++) begin
      if (sel_q == SEL_W'(k)) chan = i_wait[k*WAIT_WIDTH +: WAIT_WIDTH];
    end
  end

  // Match condition for the current WAIT cycle; prev_q is already masked.
  always_comb begin
    cur     = chan & mask_q;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TO_WIDTH'(1);
    match   = 1'b0;
    case (mode_q)
      M_RISE:  match = |(cur & ~prev_q);
      M_FALL:  match = |(~cur & prev_q & mask_q);
      M_ANY:   match = |(cur ^ prev_q);
      M_EQ:    match = (cur == (value_q & mask_q));
      M_NEQ:   match = (cur != (value_q & mask_q));
      default: match = 1'b0;
    endcase
    start_ok = (32'(i_sel) < WAIT_SIZE_U) && (i_mode <= M_NEQ);
  end

  // Next-state, capture and output logic; abort has priority over match.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    value_d   = value_q;
    timeout_d = timeout_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    to_flag_d = to_flag_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (start_ok) begin
            sel_d     = i_sel;
            mode_d    = i_mode;
            mask_d    = i_mask;
            value_d   = i_value;
            timeout_d = i_timeout;
            cnt_d     = '0;
            cycles_d  = '0;
            to_flag_d = 1'b0;
            state_d   = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (i_abort) begin
          cycles_d = cnt_q;
          state_d  = S_IDLE;
        end else begin
          prev_d  = cur;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_abort) begin
          cycles_d = cnt_q;
          state_d  = S_IDLE;
        end else begin
          prev_d = cur;
          cnt_d  = cnt_inc;
          if (match) begin
            cycles_d  = cnt_inc;
            to_flag_d = 1'b0;
            state_d   = S_DONE;
          end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
            cycles_d  = cnt_inc;
            to_flag_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    o_busy    = (state_q == S_ARM) || (state_q == S_WAIT);
    o_done    = (state_q == S_DONE);
    o_timeout = (state_q == S_DONE) && to_flag_q;
    o_err     = err_q;
    o_cycles  = cycles_q;
  end

  // State register; reset clears everything, so a mid-wait reset never yields a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      timeout_q <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      to_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      timeout_q <= timeout_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      to_flag_q <= to_flag_d;
      err_q     <= err_d;
    end
  end

endmodule
